// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] value;
    } wb_entry_t;

endpackage

// File: rtl/writeback_fifo.sv
// Synchronous FIFO of writeback entries buffering slow-path results.
module writeback_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      flush,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t pop_data,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is only safe when the head leaves on the same edge.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/writeback_unit.sv
// Single-port register-file writer: ALU results win, slow-path results queue,
// and a busy scoreboard tracks destinations with writes still outstanding.
module writeback_unit #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W,
    parameter int QDEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_dest,
    input  logic [DATA_W-1:0]      alu_value,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_dest,
    input  logic [DATA_W-1:0]      mem_value,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_dest,
    output logic [(1<<ADDR_W)-1:0] busy,
    output logic [ADDR_W-1:0]      pos,
    output logic [DATA_W-1:0]      writevalue
);

    import wb_pkg::*;

    localparam int NR = 1 << ADDR_W;

    logic [ADDR_W-1:0] pos_q, pos_d;
    logic [DATA_W-1:0] writevalue_q, writevalue_d;
    logic [NR-1:0]     busy_q, busy_d;

    wb_entry_t fifo_in, fifo_head;
    logic      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic      alu_emit;

    assign mem_ready = !fifo_full && !reset;
    assign fifo_in   = '{dest: mem_dest, value: mem_value};
    assign alu_emit  = alu_valid && (alu_dest != ZERO_REG);

    // r0 results are accepted to keep the handshake moving but never stored.
    assign fifo_push = mem_valid && mem_ready && !flush && (mem_dest != ZERO_REG);
    assign fifo_pop  = !alu_emit && !fifo_empty && !flush;

    writeback_fifo #(
        .DEPTH(QDEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .push     (fifo_push),
        .push_data(fifo_in),
        .pop      (fifo_pop),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        pos_d        = '0;
        writevalue_d = '0;
        if (alu_emit) begin
            pos_d        = alu_dest;
            writevalue_d = alu_value;
        end else if (fifo_pop) begin
            pos_d        = fifo_head.dest;
            writevalue_d = fifo_head.value;
        end
    end

    // Clear is applied before set so a same-edge claim of the retiring index survives.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            busy_d[pos_d] = 1'b0;
            if (issue_valid && (issue_dest != ZERO_REG)) begin
                busy_d[issue_dest] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pos_q        <= '0;
            writevalue_q <= '0;
            busy_q       <= '0;
        end else begin
            pos_q        <= pos_d;
            writevalue_q <= writevalue_d;
            busy_q       <= busy_d;
        end
    end

    assign pos        = pos_q;
    assign writevalue = writevalue_q;
    assign busy       = busy_q;

endmodule
